// File: rtl/mmu_sequencer.sv
// Instruction sequencer for the NxN systolic matrix-multiply unit: decodes host opcodes into
// memory reads, MMU load/compute/clear strobes and a result-streaming handshake.
module mmu_sequencer #(
  parameter int N              = 2,
  parameter int ADDR_W         = 3,
  parameter int COMPUTE_CYCLES = 4,
  parameter int IDX_W          = $clog2(N*N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mmu_load_weight,
  output logic              mmu_load_input,
  output logic              mmu_compute,
  output logic              mmu_clear_acc,
  output logic              res_capture,
  output logic              res_valid,
  output logic [IDX_W-1:0]  res_idx,
  input  logic              res_ready,
  output logic              busy,
  output logic              err_illegal
);

  localparam int NN      = N*N;
  localparam int CNT_MAX = (NN > COMPUTE_CYCLES) ? NN : COMPUTE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOADW = 3'b001;
  localparam logic [2:0] OP_LOADI = 3'b010;
  localparam logic [2:0] OP_COMP  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_CAPT  = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_LOADW, S_LOADI, S_DRAIN, S_COMPUTE, S_CAPTURE, S_STORE, S_CLEAR
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic [IDX_W-1:0]   r_idx;
  logic               r_is_w, r_ldw_q, r_ldi_q, r_err;
  logic               r_w_ok, r_i_ok, r_res_ok, r_cap_ok;

  logic w_accept, w_err_nxt, w_rd_en, w_compute, w_clear, w_capture, w_res_valid;
  logic w_set_w, w_set_i, w_set_res, w_clr_i, w_set_cap, w_clr_res, w_clr_cap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_err_nxt   = 1'b0;
    w_rd_en     = 1'b0;
    w_compute   = 1'b0;
    w_clear     = 1'b0;
    w_capture   = 1'b0;
    w_res_valid = 1'b0;
    w_set_w     = 1'b0;
    w_set_i     = 1'b0;
    w_set_res   = 1'b0;
    w_clr_i     = 1'b0;
    w_set_cap   = 1'b0;
    w_clr_res   = 1'b0;
    w_clr_cap   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (instr_valid) begin
          w_accept = 1'b1;
          case (instr_op)
            OP_NOP:   w_state_nxt = S_IDLE;
            OP_LOADW: w_state_nxt = S_LOADW;
            OP_LOADI: w_state_nxt = S_LOADI;
            OP_COMP:  if (r_w_ok && r_i_ok) w_state_nxt = S_COMPUTE; else w_err_nxt = 1'b1;
            OP_CAPT:  if (r_res_ok) w_state_nxt = S_CAPTURE; else w_err_nxt = 1'b1;
            OP_STORE: if (r_cap_ok) w_state_nxt = S_STORE; else w_err_nxt = 1'b1;
            OP_CLEAR: w_state_nxt = S_CLEAR;
            default:  w_err_nxt = 1'b1;
          endcase
        end
      end
      S_LOADW, S_LOADI: begin
        w_rd_en = 1'b1;
        if (r_cnt == '0) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        w_state_nxt = S_IDLE;
        w_set_w     = r_is_w;
        w_set_i     = !r_is_w;
      end
      S_COMPUTE: begin
        w_compute = 1'b1;
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
          w_set_res   = 1'b1;
          w_clr_i     = 1'b1;
          w_clr_cap   = 1'b1;
        end
      end
      S_CAPTURE: begin
        w_capture   = 1'b1;
        w_set_cap   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_STORE: begin
        w_res_valid = 1'b1;
        if (res_ready && r_idx == IDX_W'(NN-1)) w_state_nxt = S_IDLE;
      end
      S_CLEAR: begin
        w_clear     = 1'b1;
        w_clr_res   = 1'b1;
        w_clr_cap   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Down-counter shared by the load and compute phases; the phase ends on terminal count zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_idx   <= '0;
      r_is_w  <= 1'b0;
      r_ldw_q <= 1'b0;
      r_ldi_q <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err   <= w_err_nxt;
      r_ldw_q <= w_rd_en && (r_state == S_LOADW);
      r_ldi_q <= w_rd_en && (r_state == S_LOADI);
      if (w_accept) begin
        r_cnt  <= (instr_op == OP_COMP) ? CNT_W'(COMPUTE_CYCLES-1) : CNT_W'(NN-1);
        r_addr <= instr_addr;
        r_is_w <= (instr_op == OP_LOADW);
        r_idx  <= '0;
      end else begin
        if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        if (w_rd_en) r_addr <= r_addr + ADDR_W'(1);
        if (w_res_valid && res_ready) r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  // Operation-order legality flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_w_ok   <= 1'b0;
      r_i_ok   <= 1'b0;
      r_res_ok <= 1'b0;
      r_cap_ok <= 1'b0;
    end else begin
      if (w_set_w) r_w_ok <= 1'b1;
      if (w_set_i) r_i_ok <= 1'b1;
      else if (w_clr_i) r_i_ok <= 1'b0;
      if (w_set_res) r_res_ok <= 1'b1;
      else if (w_clr_res) r_res_ok <= 1'b0;
      if (w_set_cap) r_cap_ok <= 1'b1;
      else if (w_clr_cap) r_cap_ok <= 1'b0;
    end
  end

  assign instr_ready     = (r_state == S_IDLE) && !rst;
  assign busy            = (r_state != S_IDLE);
  assign mem_rd_en       = w_rd_en;
  assign mem_addr        = r_addr;
  assign mmu_load_weight = r_ldw_q;
  assign mmu_load_input  = r_ldi_q;
  assign mmu_compute     = w_compute;
  assign mmu_clear_acc   = w_clear;
  assign res_capture     = w_capture;
  assign res_valid       = w_res_valid;
  assign res_idx         = r_idx;
  assign err_illegal     = r_err;

endmodule

// File: doc/mmu_sequencer.md
Name: mmu_sequencer

Overview:
Instruction-driven sequencer for the 2x2 systolic matrix-multiply unit (MMU) and its shared weight/input memory. It accepts one opcode at a time from the host over a valid/ready handshake. For each opcode it generates memory read addresses, MMU load/compute/clear strobes, and a result-streaming handshake back to the host. It sits between the host instruction interface and the MMU datapath, and tracks legality of the operation order.

Parameters:
N, 2, systolic array dimension; one matrix is N*N elements
ADDR_W, 3, memory address width; addresses wrap modulo 2^ADDR_W
COMPUTE_CYCLES, 4, cycles mmu_compute is held high per COMPUTE (2*N for the skewed array)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
instr_valid  in  1  host presents an instruction
instr_ready  out  1  sequencer can accept an instruction this cycle
instr_op  in  3  opcode
instr_addr  in  ADDR_W  base memory address for the LOAD ops
mem_rd_en  out  1  memory read strobe; data returns 1 cycle later
mem_addr  out  ADDR_W  memory read address
mmu_load_weight  out  1  MMU latches a weight from memory data this cycle
mmu_load_input  out  1  MMU latches an input from memory data this cycle
mmu_compute  out  1  MMU shift/MAC enable
mmu_clear_acc  out  1  MMU accumulator clear pulse
res_capture  out  1  MMU copies its accumulators to the output registers
res_valid  out  1  result element presented to the host
res_idx  out  2  index (0..N*N-1) of the presented result element
res_ready  in  1  host accepts the presented result element
busy  out  1  high whenever the sequencer is not in IDLE
err_illegal  out  1  one-cycle pulse on an illegal or out-of-order instruction

Behaviour:
- Reset:
  - state=IDLE; flags w_ok, i_ok, res_ok, cap_ok cleared.
  - All outputs are 0, including instr_ready, while rst is high.
  - Reset mid-operation aborts immediately; no strobes remain asserted.
- Opcodes:
  - 000 NOP
  - 001 LOAD_WEIGHT
  - 010 LOAD_INPUTS
  - 100 COMPUTE
  - 101 STORE_RES
  - 110 CAPTURE_RES
  - 111 CLEAR_ACC
  - 011 illegal
- Handshake:
  - instr_ready = (state==IDLE) & !rst.
  - Accept on instr_valid & instr_ready at edge T; latch op and address.
  - The first action of the op occurs in cycle T+1.
  - Ops run back-to-back: the cycle after an op returns to IDLE, the next instruction can be accepted.
- States: IDLE, LOADW, LOADI, DRAIN, COMPUTE, CAPTURE, STORE, CLEAR.
- LOADW / LOADI:
  - Run N*N cycles with mem_rd_en=1 and mem_addr = base+k, k=0..N*N-1, wrapping mod 2^ADDR_W.
  - mmu_load_weight (or mmu_load_input) is the read strobe delayed one cycle, aligned with memory data.
  - After the last read, go to DRAIN for 1 cycle (final load strobe), then IDLE.
  - On exit set w_ok (LOADW) or i_ok (LOADI).
  - Total occupancy is N*N+1 cycles.
- COMPUTE:
  - If !(w_ok & i_ok): pulse err_illegal at T+1, stay IDLE.
  - Otherwise hold mmu_compute=1 for exactly COMPUTE_CYCLES cycles, then IDLE.
  - On exit: set res_ok, clear i_ok and cap_ok; w_ok is retained (weights are stationary).
- CAPTURE_RES:
  - If !res_ok: err_illegal.
  - Otherwise res_capture=1 for one cycle, set cap_ok, then IDLE.
- STORE_RES:
  - If !cap_ok: err_illegal.
  - Otherwise res_valid=1 with res_idx starting at 0.
  - res_idx advances only on res_valid & res_ready; res_valid and res_idx stay stable while stalled.
  - After the handshake of index N*N-1: res_valid=0, return to IDLE.
  - cap_ok is retained, so repeat STORE is allowed.
- CLEAR_ACC:
  - mmu_clear_acc=1 for one cycle; clear res_ok and cap_ok; then IDLE.
- NOP: consumed with no outputs; stays IDLE.
- Illegal opcode 011: err_illegal pulse at T+1; flags unchanged.
- Mutual exclusion: at most one of mmu_load_weight, mmu_load_input, mmu_compute, mmu_clear_acc, res_capture is high in any cycle.
- instr_valid while busy is ignored; the host holds the instruction until accepted.

Test Plan:
- Reset then LOAD_WEIGHT base=6 -> mem_rd_en for 4 cycles with mem_addr 6,7,0,1; mmu_load_weight in cycles T+2..T+5; instr_ready high again at T+6.
- COMPUTE before any load -> err_illegal pulse at T+1; no mmu_compute; instr_ready back high at T+1.
- LOADW(0), LOADI(4), COMPUTE -> mmu_compute high exactly 4 cycles; a second COMPUTE issued immediately after -> err_illegal (i_ok cleared).
- CAPTURE then STORE with res_ready low for 3 cycles at idx 1 -> res_idx sequence 0,1,1,1,1,2,3 with res_valid held; IDLE after idx 3 accepted.
- STORE after CLEAR_ACC -> mmu_clear_acc single pulse, then err_illegal on STORE; opcode 011 -> err_illegal, flags unchanged.
- Assert rst during cycle 2 of LOADI -> all outputs 0 immediately; after release, COMPUTE -> err_illegal (flags cleared).
